// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage datapath: default widths, the
// operand-source select encoding and the hardwired zero register number.
package pipe_pkg;

  localparam int PIPE_DATA_W = 32;
  localparam int PIPE_ADDR_W = 5;
  localparam int PIPE_CNT_W  = 16;

  // Register number that always reads as zero and ignores writes.
  localparam int ZERO_REG = 0;

  // Where a resolved operand comes from, lowest to highest priority.
  typedef enum logic [2:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM_ALU,
    FWD_MEM_MO,
    FWD_EX
  } fwd_sel_e;

endpackage

// File: rtl/pipe_id_fwd_if.sv
// ID-stage operand/hazard bundle. The master side is whatever drives the
// pipeline-register and bypass values; the slave side is the ID stage.
interface pipe_id_fwd_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int CNT_W  = PIPE_CNT_W
);

  // Current ID instruction
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              use_rs;
  logic              use_rt;

  // EX producer
  logic              ewreg;
  logic              em2reg;
  logic [ADDR_W-1:0] ern;
  logic [DATA_W-1:0] ealu;

  // MEM producer
  logic              mwreg;
  logic              mm2reg;
  logic [ADDR_W-1:0] mrn;
  logic [DATA_W-1:0] malu;
  logic [DATA_W-1:0] mmo;

  // WB write port
  logic              wwreg;
  logic [ADDR_W-1:0] wrn;
  logic [DATA_W-1:0] wdi;

  // Results
  logic [DATA_W-1:0] da;
  logic [DATA_W-1:0] db;
  logic              rsrtequ;
  logic              wpcir;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output rs, rt, use_rs, use_rt,
    output ewreg, em2reg, ern, ealu,
    output mwreg, mm2reg, mrn, malu, mmo,
    output wwreg, wrn, wdi,
    input  da, db, rsrtequ, wpcir, stall_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt,
    input  ewreg, em2reg, ern, ealu,
    input  mwreg, mm2reg, mrn, malu, mmo,
    input  wwreg, wrn, wdi,
    output da, db, rsrtequ, wpcir, stall_cnt
  );

endinterface

// File: rtl/pipe_id_fwd_regfile_wt.sv
// regfile_wt: general-purpose register file, two read ports, one write
// port. Register 0 is hardwired to zero; a read of the register being
// written this cycle returns the incoming write data.
module regfile_wt
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int                NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0   = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [NREG];
  logic              wr_ok;

  assign wr_ok = we && (wa != R0);

  // Storage update: synchronous clear of every entry, otherwise one write.
  // NOTE: clearing the whole array on reset is required by the pipeline's
  // restart semantics; it turns the array into flops rather than a RAM macro.
  // NOTE: sequential state uses <= so every reader sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wa] <= wd;
    end
  end

  // Read ports: r0 first, then same-cycle write-through, then the array.
  assign rd1 = (ra1 == R0)            ? '0 :
               (wr_ok && (wa == ra1)) ? wd : mem[ra1];
  assign rd2 = (ra2 == R0)            ? '0 :
               (wr_ok && (wa == ra2)) ? wd : mem[ra2];

endmodule

// File: rtl/pipe_id_fwd.sv
// pipe_id_fwd: ID-stage datapath. Register file with write-through,
// EX/MEM operand forwarding, load-use interlock (wpcir), branch-compare
// flag and a saturating stall counter.
// Build option: define PIPE_FWD_EN for EX/MEM bypassing with a load-use
// only interlock; without it every EX/MEM RAW on a used source stalls.
module pipe_id_fwd
  import pipe_pkg::*;
#(
  parameter int DATA_W = PIPE_DATA_W,
  parameter int ADDR_W = PIPE_ADDR_W,
  parameter int CNT_W  = PIPE_CNT_W
) (
  input  logic         clock,
  input  logic         resetn,
  pipe_id_fwd_if.slave bus
);

`ifdef PIPE_FWD_EN
  localparam bit FWD_ON = 1'b1;
`else
  localparam bit FWD_ON = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] R0      = ADDR_W'(ZERO_REG);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic [DATA_W-1:0] rf_a, rf_b;
  logic [DATA_W-1:0] da, db;
  logic              ex_rs, ex_rt, mem_rs, mem_rt, wb_rs, wb_rt;
  logic              ex_used, mem_used, stall, wpcir;
  logic [CNT_W-1:0]  cnt;
  fwd_sel_e          sel_a, sel_b;

  regfile_wt #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rf (
    .clock  (clock),
    .resetn (resetn),
    .we     (bus.wwreg),
    .wa     (bus.wrn),
    .wd     (bus.wdi),
    .ra1    (bus.rs),
    .ra2    (bus.rt),
    .rd1    (rf_a),
    .rd2    (rf_b)
  );

  // Producer matches per source register (r0 never matches).
  assign ex_rs  = bus.ewreg && (bus.ern != R0) && (bus.ern == bus.rs);
  assign ex_rt  = bus.ewreg && (bus.ern != R0) && (bus.ern == bus.rt);
  assign mem_rs = bus.mwreg && (bus.mrn != R0) && (bus.mrn == bus.rs);
  assign mem_rt = bus.mwreg && (bus.mrn != R0) && (bus.mrn == bus.rt);
  assign wb_rs  = bus.wwreg && (bus.wrn != R0) && (bus.wrn == bus.rs);
  assign wb_rt  = bus.wwreg && (bus.wrn != R0) && (bus.wrn == bus.rt);

  // Only sources the instruction really reads can interlock.
  assign ex_used  = (bus.use_rs && ex_rs)  || (bus.use_rt && ex_rt);
  assign mem_used = (bus.use_rs && mem_rs) || (bus.use_rt && mem_rt);
  assign stall    = FWD_ON ? (ex_used && bus.em2reg) : (ex_used || mem_used);

  function automatic fwd_sel_e pick(input logic ex_hit, input logic mem_hit,
                                    input logic mem_load, input logic wb_hit);
    if (FWD_ON && ex_hit)       return FWD_EX;
    else if (FWD_ON && mem_hit) return mem_load ? FWD_MEM_MO : FWD_MEM_ALU;
    else if (wb_hit)            return FWD_WB;
    else                        return FWD_RF;
  endfunction

  function automatic logic [DATA_W-1:0] mux_operand(
    input fwd_sel_e sel, input logic [DATA_W-1:0] rf_q,
    input logic [DATA_W-1:0] ex_v, input logic [DATA_W-1:0] malu_v,
    input logic [DATA_W-1:0] mmo_v);
    case (sel)
      FWD_EX:      return ex_v;
      FWD_MEM_ALU: return malu_v;
      FWD_MEM_MO:  return mmo_v;
      default:     return rf_q; // array value already carries write-through
    endcase
  endfunction

  // Operand resolution; outputs forced to zero while reset is asserted.
  // NOTE: every always_comb output gets a default first so no latch forms.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    da    = '0;
    db    = '0;
    if (resetn) begin
      sel_a = pick(ex_rs, mem_rs, bus.mm2reg, wb_rs);
      sel_b = pick(ex_rt, mem_rt, bus.mm2reg, wb_rt);
      da    = mux_operand(sel_a, rf_a, bus.ealu, bus.malu, bus.mmo);
      db    = mux_operand(sel_b, rf_b, bus.ealu, bus.malu, bus.mmo);
    end
  end

  assign wpcir = !resetn || !stall;

  // Saturating count of stall cycles since the last reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt <= '0;
    end else if (!wpcir && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.da        = da;
  assign bus.db        = db;
  assign bus.rsrtequ   = (da == db);
  assign bus.wpcir     = wpcir;
  assign bus.stall_cnt = cnt;

endmodule

// File: tb/tb_pipe_id_fwd.sv
// Self-checking bench for pipe_id_fwd: directed vector table, hand-written
// reset/saturation sequences and randomized traffic against a reference
// model. A second instance with a 2-bit counter shares the stimulus.
module tb_pipe_id_fwd;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 16;

`ifdef PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clock;
  logic resetn;

  pipe_id_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
  pipe_id_fwd_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2))  sbus ();

  pipe_id_fwd #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  pipe_id_fwd #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(2)) dut_sat (
    .clock  (clock),
    .resetn (resetn),
    .bus    (sbus.slave)
  );

  assign sbus.rs     = bus.rs;
  assign sbus.rt     = bus.rt;
  assign sbus.use_rs = bus.use_rs;
  assign sbus.use_rt = bus.use_rt;
  assign sbus.ewreg  = bus.ewreg;
  assign sbus.em2reg = bus.em2reg;
  assign sbus.ern    = bus.ern;
  assign sbus.ealu   = bus.ealu;
  assign sbus.mwreg  = bus.mwreg;
  assign sbus.mm2reg = bus.mm2reg;
  assign sbus.mrn    = bus.mrn;
  assign sbus.malu   = bus.malu;
  assign sbus.mmo    = bus.mmo;
  assign sbus.wwreg  = bus.wwreg;
  assign sbus.wrn    = bus.wrn;
  assign sbus.wdi    = bus.wdi;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [4:0]  rs, rt;
    logic        use_rs, use_rt;
    logic        ewreg, em2reg;
    logic [4:0]  ern;
    logic        mwreg, mm2reg;
    logic [4:0]  mrn;
    logic        wwreg;
    logic [4:0]  wrn;
    logic [31:0] wdi, ealu, malu, mmo;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] exp_da, exp_db;
    logic        exp_wpcir;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: architectural registers and stall count.
  logic [31:0] mreg [32];
  int unsigned mcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic stim_t st(
    input logic [4:0] rs, input logic [4:0] rt, input logic use_rs, input logic use_rt,
    input logic ewreg, input logic em2reg, input logic [4:0] ern,
    input logic mwreg, input logic mm2reg, input logic [4:0] mrn,
    input logic wwreg, input logic [4:0] wrn, input logic [31:0] wdi,
    input logic [31:0] ealu, input logic [31:0] malu, input logic [31:0] mmo);
    stim_t s;
    s.rs = rs; s.rt = rt; s.use_rs = use_rs; s.use_rt = use_rt;
    s.ewreg = ewreg; s.em2reg = em2reg; s.ern = ern;
    s.mwreg = mwreg; s.mm2reg = mm2reg; s.mrn = mrn;
    s.wwreg = wwreg; s.wrn = wrn; s.wdi = wdi;
    s.ealu = ealu; s.malu = malu; s.mmo = mmo;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    bus.rs = s.rs;       bus.rt = s.rt;
    bus.use_rs = s.use_rs; bus.use_rt = s.use_rt;
    bus.ewreg = s.ewreg; bus.em2reg = s.em2reg; bus.ern = s.ern; bus.ealu = s.ealu;
    bus.mwreg = s.mwreg; bus.mm2reg = s.mm2reg; bus.mrn = s.mrn;
    bus.malu = s.malu;   bus.mmo = s.mmo;
    bus.wwreg = s.wwreg; bus.wrn = s.wrn;       bus.wdi = s.wdi;
  endtask

  // Model: value an operand must take this cycle, straight from the rules.
  function automatic logic [31:0] m_operand(input logic [4:0] src);
    if (!resetn) return 32'h0;
    if (FWD && bus.ewreg && bus.ern != 0 && bus.ern == src) return bus.ealu;
    if (FWD && bus.mwreg && bus.mrn != 0 && bus.mrn == src)
      return bus.mm2reg ? bus.mmo : bus.malu;
    if (bus.wwreg && bus.wrn != 0 && bus.wrn == src) return bus.wdi;
    return (src == 0) ? 32'h0 : mreg[src];
  endfunction

  function automatic bit m_used_hit(input logic [4:0] n);
    return (n != 0) && ((bus.use_rs && n == bus.rs) || (bus.use_rt && n == bus.rt));
  endfunction

  function automatic bit m_stall();
    if (!resetn) return 1'b0;
    if (FWD) return bus.ewreg && bus.em2reg && m_used_hit(bus.ern);
    return (bus.ewreg && m_used_hit(bus.ern)) || (bus.mwreg && m_used_hit(bus.mrn));
  endfunction

  // Advance the model across the coming rising edge.
  task automatic m_commit();
    if (!resetn) begin
      for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
      mcnt = 0;
    end else begin
      if (m_stall() && mcnt < 65535) mcnt++;
      if (bus.wwreg && bus.wrn != 0) mreg[bus.wrn] = bus.wdi;
    end
  endtask

  task automatic check_all(input string tag);
    logic [31:0] eda, edb;
    int unsigned sat;
    eda = m_operand(bus.rs);
    edb = m_operand(bus.rt);
    sat = (mcnt > 3) ? 3 : mcnt;
    check({tag, ".da"}, bus.da, eda);
    check({tag, ".db"}, bus.db, edb);
    check({tag, ".rsrtequ"}, bus.rsrtequ, eda == edb);
    check({tag, ".wpcir"}, bus.wpcir, !m_stall());
    check({tag, ".stall_cnt"}, bus.stall_cnt, mcnt);
    check({tag, ".sat_cnt"}, sbus.stall_cnt, sat);
  endtask

  task automatic finish_cycle();
    m_commit();
    @(posedge clock);
    #1;
  endtask

  stim_t zero_s;
  stim_t stall_s;
  vec_t  vec [10];

  initial begin
    zero_s  = st(0,0,0,0, 0,0,0, 0,0,0, 0,0,32'h0, 32'h0,32'h0,32'h0);
    stall_s = st(0,7,0,1, 1,1,7, 0,0,0, 0,0,32'h0, 32'h0,32'h0,32'h0);
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    mcnt = 0;

    // Directed vectors, applied back to back after reset.
    vec[0].s = st(5,0,1,0, 0,0,0, 0,0,0, 1,5,32'h1234, 0,0,0);
    vec[0].exp_da = 32'h1234; vec[0].exp_db = 0; vec[0].exp_wpcir = 1;
    vec[1].s = st(5,0,1,0, 0,0,0, 0,0,0, 0,5,32'h9999, 0,0,0);
    vec[1].exp_da = 32'h1234; vec[1].exp_db = 0; vec[1].exp_wpcir = 1;
    vec[2].s = st(0,0,1,1, 0,0,0, 0,0,0, 1,0,32'hFFFF_FFFF, 0,0,0);
    vec[2].exp_da = 0; vec[2].exp_db = 0; vec[2].exp_wpcir = 1;
    vec[3].s = st(0,0,1,1, 1,1,0, 0,0,0, 0,0,0, 32'hDEAD,0,0);
    vec[3].exp_da = 0; vec[3].exp_db = 0; vec[3].exp_wpcir = 1;
    vec[4].s = st(5,7,1,1, 1,1,7, 0,0,0, 0,0,0, 32'h77,0,0);
    vec[4].exp_da = 32'h1234; vec[4].exp_db = FWD ? 32'h77 : 32'h0; vec[4].exp_wpcir = 0;
    vec[5].s = st(5,7,1,0, 1,1,7, 0,0,0, 0,0,0, 32'h77,0,0);
    vec[5].exp_da = 32'h1234; vec[5].exp_db = FWD ? 32'h77 : 32'h0; vec[5].exp_wpcir = 1;
    vec[6].s = st(3,0,1,0, 1,0,3, 1,0,3, 0,0,0, 32'hA,32'hB,32'hC);
    vec[6].exp_da = FWD ? 32'hA : 32'h0; vec[6].exp_db = 0; vec[6].exp_wpcir = FWD;
    vec[7].s = st(3,0,1,0, 0,0,3, 1,0,3, 0,0,0, 32'hA,32'hB,32'hC);
    vec[7].exp_da = FWD ? 32'hB : 32'h0; vec[7].exp_db = 0; vec[7].exp_wpcir = FWD;
    vec[8].s = st(3,0,1,0, 0,0,3, 1,1,3, 0,0,0, 32'hA,32'hB,32'hC);
    vec[8].exp_da = FWD ? 32'hC : 32'h0; vec[8].exp_db = 0; vec[8].exp_wpcir = FWD;
    vec[9].s = st(4,0,1,0, 0,0,0, 1,0,4, 0,0,0, 0,32'hB,0);
    vec[9].exp_da = FWD ? 32'hB : 32'h0; vec[9].exp_db = 0; vec[9].exp_wpcir = FWD;

    // Reset for two cycles with a pending write and a load-use pattern.
    resetn = 1'b0;
    apply(st(9,7,1,1, 1,1,7, 1,0,9, 1,9,32'h55, 32'h11,32'h22,32'h33));
    @(negedge clock);
    check("rst0.da", bus.da, 0);
    check("rst0.db", bus.db, 0);
    check("rst0.rsrtequ", bus.rsrtequ, 1);
    check("rst0.wpcir", bus.wpcir, 1);
    finish_cycle();
    @(negedge clock);
    check_all("rst1");
    check("rst1.cnt_zero", bus.stall_cnt, 0);
    finish_cycle();

    // Every register reads zero after reset (r9 write was suppressed).
    resetn = 1'b1;
    for (int r = 1; r < 32; r++) begin
      apply(zero_s);
      bus.rs = 5'(r);
      bus.rt = 5'(r);
      @(negedge clock);
      check($sformatf("rd_r%0d", r), {bus.da, bus.db}, 64'h0);
      if (r == 31) begin
        check("post_rst.wpcir", bus.wpcir, 1);
        check("post_rst.stall_cnt", bus.stall_cnt, 0);
      end
      finish_cycle();
    end

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      apply(vec[i].s);
      @(negedge clock);
      check($sformatf("vec%0d.da", i), bus.da, vec[i].exp_da);
      check($sformatf("vec%0d.db", i), bus.db, vec[i].exp_db);
      check($sformatf("vec%0d.rsrtequ", i), bus.rsrtequ, vec[i].exp_da == vec[i].exp_db);
      check($sformatf("vec%0d.wpcir", i), bus.wpcir, vec[i].exp_wpcir);
      check($sformatf("vec%0d.stall_cnt", i), bus.stall_cnt, mcnt);
      if (i == 5) check("one_stall.stall_cnt", bus.stall_cnt, 1);
      finish_cycle();
    end

    // Reset asserted in the middle of a stall: released at once, no residue.
    apply(stall_s);
    bus.rs = 5; bus.use_rs = 1'b1;
    @(negedge clock);
    check("midrst.pre_wpcir", bus.wpcir, 0);
    finish_cycle();
    resetn = 1'b0;
    @(negedge clock);
    check("midrst.wpcir", bus.wpcir, 1);
    check("midrst.da", bus.da, 0);
    check("midrst.rsrtequ", bus.rsrtequ, 1);
    finish_cycle();
    resetn = 1'b1;
    apply(zero_s);
    bus.rs = 5; bus.use_rs = 1'b1;
    @(negedge clock);
    check("midrst.cnt_cleared", bus.stall_cnt, 0);
    check("midrst.r5_cleared", bus.da, 0);
    finish_cycle();

    // Long stall: 16-bit counter reaches 6, 2-bit counter pins at 3.
    apply(stall_s);
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check_all($sformatf("sat%0d", c));
      finish_cycle();
    end
    apply(zero_s);
    @(negedge clock);
    check("sat.main_cnt", bus.stall_cnt, 6);
    check("sat.small_cnt", sbus.stall_cnt, 3);
    finish_cycle();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      stim_t s;
      s = st(5'($urandom_range(0,7)), 5'($urandom_range(0,7)),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 5'($urandom_range(0,7)),
             1'($urandom_range(0,1)), 1'($urandom_range(0,1)), 5'($urandom_range(0,7)),
             1'($urandom_range(0,1)), 5'($urandom_range(0,7)), $urandom(),
             $urandom(), $urandom(), $urandom());
      resetn = ($urandom_range(0,49) != 0);
      apply(s);
      @(negedge clock);
      check_all($sformatf("rnd%0d", k));
      finish_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipe_id_fwd.md
# pipe_id_fwd

Parametrised successor of the pipeline ID stage datapath. It holds the general-purpose register file with write-through, EX/MEM/WB operand forwarding, the load-use interlock (`wpcir`), the branch-compare flag and a saturating stall counter. It sits between the IF/ID pipeline register and the ID/EX pipeline register, and feeds `da`/`db` to EX and `rsrtequ` to the control unit.

## Interface
- `DATA_W`, 32: register/data width.
- `ADDR_W`, 5: register-number width; register count is 2**ADDR_W.
- `CNT_W`, 16: stall-counter width.
- `clock`  in  1: single clock, all state on rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `rs`, `rt`  in  ADDR_W: source register numbers (`inst[25:21]`, `inst[20:16]`).
- `use_rs`, `use_rt`  in  1: the current ID instruction actually reads rs/rt.
- `ewreg`, `em2reg`  in  1; `ern`  in  ADDR_W: EX-stage write-enable, load flag and destination.
- `mwreg`, `mm2reg`  in  1; `mrn`  in  ADDR_W: MEM-stage equivalents.
- `wwreg`  in  1; `wrn`  in  ADDR_W; `wdi`  in  DATA_W: WB write port.
- `ealu`, `malu`, `mmo`  in  DATA_W: EX ALU result, MEM ALU result, MEM load data.
- `da`, `db`  out  DATA_W: resolved operands.
- `rsrtequ`  out  1: `da == db`.
- `wpcir`  out  1: 1 = PC and IF/ID advance; 0 = stall.
- `stall_cnt`  out  CNT_W: number of cycles with `wpcir`=0 since reset, saturating.

## Operation
- Register 0 reads as 0 and is never written. A write to `wrn`=0 is discarded.
- Write: at a rising edge with `resetn`=1, `wwreg`=1 and `wrn`!=0, `reg[wrn]` <= `wdi`.
- Write-through (always built): if `wwreg` and `wrn`!=0 and `wrn`==rs, the operand is `wdi`, not the array value. The same applies to rt.
- Forwarding per operand, priority high to low (with FWD_EN):
  - EX: `ewreg`, `ern`!=0, `ern`==src → `ealu`.
  - MEM: `mwreg`, `mrn`!=0, `mrn`==src → `mm2reg` ? `mmo` : `malu`.
  - WB write-through.
  - Array value.
- Load-use hazard: `ewreg & em2reg & ern!=0 & ((use_rs & ern==rs) | (use_rt & ern==rt))` → `wpcir`=0. During the stall, `da`/`db` follow the priority rules (value is don't-care downstream).
- A source register whose `use_*` is 0 never causes a stall, but is still forwarded.
- `rsrtequ` is computed on the final `da`/`db`.
- `stall_cnt` increments every cycle `wpcir`=0 and holds at all-ones.

## Timing
- Reads, forwarding, `wpcir` and `rsrtequ` are combinational within the cycle. Write latency is 1 edge.
- Reset (synchronous, `resetn`=0 at an edge): all registers <= 0, `stall_cnt` <= 0.
- While `resetn`=0: `da`=`db`=0, `rsrtequ`=1, `wpcir`=1. The WB write is suppressed on that edge.
- Reset asserted mid-stall: stall is released in the same cycle; there is no residual state.
- Simultaneous EX and MEM match on the same register: EX wins. EX-load match stalls even if MEM also matches.
- A WB write and a read of the same register in one cycle return `wdi`. The array is updated at the edge.
- `stall_cnt` saturation: at all-ones, a further stall cycle leaves the counter at all-ones.

## Configuration
- `PIPE_FWD_EN` defined: EX/MEM forwarding and the load-use-only interlock, as above.
- Undefined: no EX/MEM forwarding paths; WB write-through is kept. Stall rule becomes `(ewreg & ern!=0 & ern matches a used source) | (mwreg & mrn!=0 & mrn matches a used source)`. Any RAW on an EX or MEM producer stalls, up to 2 cycles.

## Structure
- Shared package `pipe_pkg`:
  - `DATA_W` and `ADDR_W` defaults.
  - Forward-select enum {FWD_RF, FWD_WB, FWD_MEM_ALU, FWD_MEM_MO, FWD_EX}.
  - Zero-register constant.
- One sub-module, `regfile_wt`: storage array, synchronous reset, r0 hardwiring and write-through. Two read ports and one write port.
- Forward selection, hazard logic and the counter live in the top module.

## Test plan
- Reset held 2 cycles, then read r1..r31 → all 0; `stall_cnt`=0; `wpcir`=1.
- WB writes `wrn`=5, `wdi`=0x1234 while rs=5 → `da`=0x1234 in the same cycle. Next cycle with `wwreg`=0 → `da`=0x1234.
- `ewreg`=1, `ern`=3, `ealu`=0xA; `mwreg`=1, `mrn`=3, `malu`=0xB; rs=3 → `da`=0xA. Drop `ewreg` → `da`=0xB. Set `mm2reg`=1, `mmo`=0xC → `da`=0xC.
- `ewreg`=`em2reg`=1, `ern`=7, rt=7, `use_rt`=1 → `wpcir`=0 for 1 cycle, `stall_cnt`=1. The same case with `use_rt`=0 → `wpcir`=1.
- Write to r0 with 0xFFFF_FFFF, rs=rt=0 → `da`=`db`=0 and `rsrtequ`=1. With `ern`=0, `em2reg`=1 → no stall.
- Without `PIPE_FWD_EN`: `mwreg`=1, `mrn`=4, rs=4, `use_rs`=1 → `wpcir`=0. Force `stall_cnt` to all-ones via a long stall with CNT_W=2 → counter holds at 3.
